// File: rtl/branch_tag_allocator_pkg.sv
// Shared sizing and bus types for the branch tag allocator.
package branch_tag_allocator_pkg;

   localparam int unsigned N               = 3;
   localparam int unsigned B_MASK_WIDTH    = 4;
   localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1);

   typedef logic [B_MASK_WIDTH-1:0]        b_mask_t;
   typedef logic [N-1:0][B_MASK_WIDTH-1:0] slot_masks_t;
   typedef logic [NUM_SCALAR_BITS-1:0]     num_scalar_t;

endpackage

// File: rtl/branch_tag_allocator_if.sv
// Dispatch/resolve bundle between the front end and the branch tag allocator.
interface branch_tag_allocator_if;
   import branch_tag_allocator_pkg::*;

   logic [N-1:0] branch_req;
   num_scalar_t  num_dispatched;
   logic         resolve_valid;
   b_mask_t      resolve_tag;
   logic         resolve_mispredict;
   slot_masks_t  branch_tags;
   slot_masks_t  slot_b_mask;
   num_scalar_t  num_dispatch_ok;
   b_mask_t      b_mask_reg;
   b_mask_t      squash_mask;

   modport master (
      output branch_req, num_dispatched, resolve_valid, resolve_tag, resolve_mispredict,
      input  branch_tags, slot_b_mask, num_dispatch_ok, b_mask_reg, squash_mask
   );

   modport slave (
      input  branch_req, num_dispatched, resolve_valid, resolve_tag, resolve_mispredict,
      output branch_tags, slot_b_mask, num_dispatch_ok, b_mask_reg, squash_mask
   );

endinterface

// File: rtl/branch_tag_allocator_psel.sv
// Multi-grant priority selector: grant r is the r-th lowest set bit of req (one-hot), 0 if none left.
module psel_multi #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned REQS  = 1
) (
   input  logic [WIDTH-1:0]            req,
   output logic [REQS-1:0][WIDTH-1:0]  gnt
);

   logic [WIDTH-1:0] remaining;

   always_comb begin
      remaining = req;
      gnt       = '0;
      for (int r = 0; r < REQS; r++) begin
         gnt[r]    = remaining & (~remaining + WIDTH'(1));
         remaining = remaining & ~gnt[r];
      end
   end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch checkpoint tag pool: in-order tag allocation per dispatch bundle, free on resolve,
// and younger-tag kill on mispredict via a per-tag dependency matrix.
module branch_tag_allocator
   import branch_tag_allocator_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   branch_tag_allocator_if.slave  bus
);

   b_mask_t     b_mask_q, b_mask_d;
   b_mask_t     dep_q [B_MASK_WIDTH];
   b_mask_t     dep_d [B_MASK_WIDTH];
   b_mask_t     free_mask;
   slot_masks_t grants;
   slot_masks_t tags;
   slot_masks_t sbm;
   num_scalar_t ok;
   b_mask_t     acc;
   b_mask_t     pick;
   logic        stalled;
   int          rank;
   logic        hit;
   logic        mispredict;
   b_mask_t     kill;
   b_mask_t     clear_mask;

   assign free_mask = ~b_mask_q;

   psel_multi #(.WIDTH(B_MASK_WIDTH), .REQS(N)) u_psel (
      .req (free_mask),
      .gnt (grants)
   );

   // Hand the j-th free tag to the j-th branch slot; first branch without a tag caps the bundle.
   always_comb begin
      acc     = b_mask_q;
      rank    = 0;
      stalled = 1'b0;
      ok      = num_scalar_t'(N);
      tags    = '0;
      sbm     = '0;
      pick    = '0;
      for (int i = 0; i < N; i++) begin
         sbm[i] = acc;
         pick   = '0;
         for (int r = 0; r < N; r++) begin
            if (r == rank) pick = grants[r];
         end
         if (bus.branch_req[i] && !stalled) begin
            if (pick != '0) begin
               tags[i] = pick;
               acc     = acc | pick;
               rank    = rank + 1;
            end else begin
               stalled = 1'b1;
               ok      = num_scalar_t'(i);
            end
         end
      end
   end

   assign hit        = bus.resolve_valid && ((bus.resolve_tag & b_mask_q) != '0);
   assign mispredict = hit && bus.resolve_mispredict;

   // A live tag dies with the mispredicted branch if it was allocated while that branch was in flight.
   always_comb begin
      kill = '0;
      for (int t = 0; t < B_MASK_WIDTH; t++) begin
         kill[t] = bus.resolve_tag[t] || (b_mask_q[t] && ((dep_q[t] & bus.resolve_tag) != '0));
      end
   end

   assign clear_mask = !hit ? '0 : (bus.resolve_mispredict ? kill : bus.resolve_tag);

   always_comb begin
      b_mask_d = b_mask_q & ~clear_mask;
      for (int t = 0; t < B_MASK_WIDTH; t++) begin
         dep_d[t] = (mispredict && kill[t]) ? '0 : (dep_q[t] & ~clear_mask);
      end
      if (!mispredict) begin
         for (int i = 0; i < N; i++) begin
            if ((num_scalar_t'(i) < bus.num_dispatched) && (tags[i] != '0)) begin
               b_mask_d = b_mask_d | tags[i];
               for (int t = 0; t < B_MASK_WIDTH; t++) begin
                  if (tags[i][t]) dep_d[t] = sbm[i] & ~clear_mask;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         b_mask_q <= '0;
         for (int t = 0; t < B_MASK_WIDTH; t++) dep_q[t] <= '0;
      end else begin
         b_mask_q <= b_mask_d;
         for (int t = 0; t < B_MASK_WIDTH; t++) dep_q[t] <= dep_d[t];
      end
   end

   assign bus.branch_tags     = tags;
   assign bus.slot_b_mask     = sbm;
   assign bus.num_dispatch_ok = ok;
   assign bus.b_mask_reg      = b_mask_q;
   assign bus.squash_mask     = mispredict ? kill : '0;

   a_dispatch_within_ok: assert property (@(posedge clock) disable iff (!reset)
      (mispredict || (bus.num_dispatched <= ok)));

endmodule
